// File: rtl/qch_pkg.sv
// Shared types and helpers for the Q-channel low-power controller.
package qch_pkg;

    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        DENIED  = 3'd3
    } qch_state_t;

    // Number of bits needed to hold max_val (never less than one).
    function automatic int unsigned qch_cnt_w(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((max_val >> w) != 0)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/qch_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module qch_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, hold at all-ones, or step by one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/qchannel_ctrl.sv
// Q-channel low-power controller between the system power controller and a
// core: quiescence window, interrupt wake requests and an entry counter.
// Build option: define QCH_DENY_EN to add deny on pending interrupt and on
// drain timeout (DENIED state plus timeout counter); otherwise qdeny is 0.
module qchannel_ctrl #(
    parameter int unsigned QUIESCE_CYCLES = 4,
    parameter int unsigned DENY_TIMEOUT   = 64,
    parameter int unsigned IRQ_W          = 32,
    parameter int unsigned STAT_W         = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              qreqn,
    output logic              qacceptn,
    output logic              qdeny,
    input  logic              bus_busy,
    input  logic              core_idle,
    input  logic [IRQ_W-1:0]  irq_in,
    input  logic [IRQ_W-1:0]  irq_mask,
    output logic              gate_n,
    output logic [IRQ_W-1:0]  irq_gated,
    output logic              wake_req,
    output logic [STAT_W-1:0] stop_count
);

    import qch_pkg::*;

    if ((QUIESCE_CYCLES == 0) || (QUIESCE_CYCLES > 255)) begin : g_bad_quiesce
        $error("QUIESCE_CYCLES must be in 1..255");
    end
    if ((DENY_TIMEOUT < 2) || (DENY_TIMEOUT > 65535)) begin : g_bad_timeout
        $error("DENY_TIMEOUT must be in 2..65535");
    end

    localparam int unsigned QC_W = qch_cnt_w(QUIESCE_CYCLES - 1);

    qch_state_t state_q, state_d;
    logic       qacceptn_q, qacceptn_d;
    logic       gate_n_q, gate_n_d;
    logic       wake_req_q, wake_req_d;

    logic            pend;
    logic            in_drain;
    logic            accept;
    logic            deny_run;
    logic            deny_drain;
    logic [QC_W-1:0] q_cnt;

    assign pend     = |(irq_in & irq_mask);
    assign in_drain = (state_q == DRAIN);

    // Quiesce window: counts consecutive idle DRAIN cycles, cleared outside
    // DRAIN so every entry starts from zero.
    qch_sat_cnt #(
        .W(QC_W)
    ) u_quiesce_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (!in_drain || !core_idle),
        .en_i   (in_drain && core_idle),
        .cnt_o  (q_cnt)
    );

    assign accept = in_drain && core_idle && (q_cnt == QC_W'(QUIESCE_CYCLES - 1));

    qch_sat_cnt #(
        .W(STAT_W)
    ) u_stop_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (1'b0),
        .en_i   (accept),
        .cnt_o  (stop_count)
    );

`ifdef QCH_DENY_EN
    localparam int unsigned TO_W = qch_cnt_w(DENY_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
    logic            qdeny_q, qdeny_d;

    qch_sat_cnt #(
        .W(TO_W)
    ) u_timeout_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (!in_drain),
        .en_i   (in_drain),
        .cnt_o  (to_cnt)
    );

    assign deny_run   = pend;
    assign deny_drain = pend || (to_cnt == TO_W'(DENY_TIMEOUT - 1));
    assign qdeny_d    = (state_d == DENIED);
    assign qdeny      = qdeny_q;

    // Registered deny output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            qdeny_q <= 1'b0;
        end else begin
            qdeny_q <= qdeny_d;
        end
    end
`else
    assign deny_run   = 1'b0;
    assign deny_drain = 1'b0;
    assign qdeny      = 1'b0;
`endif

    // Next state and registered-output values; acceptance beats deny in DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (qreqn) state_d = RUN;
            RUN: begin
                if (!qreqn) begin
                    if (deny_run) begin
                        state_d = DENIED;
                    end else if (!bus_busy) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_d = STOPPED;
                end else if (deny_drain) begin
                    state_d = DENIED;
                end
            end
            DENIED:  if (qreqn) state_d = RUN;
            default: state_d = STOPPED;
        endcase

        qacceptn_d = (state_d != STOPPED);
        gate_n_d   = (state_d == RUN) || (state_d == DENIED);
        // Wake is only raised while staying in STOPPED, so it drops on exit.
        wake_req_d = (state_q == STOPPED) && (state_d == STOPPED) && pend;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= STOPPED;
            qacceptn_q <= 1'b0;
            gate_n_q   <= 1'b0;
            wake_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            qacceptn_q <= qacceptn_d;
            gate_n_q   <= gate_n_d;
            wake_req_q <= wake_req_d;
        end
    end

    assign qacceptn  = qacceptn_q;
    assign gate_n    = gate_n_q;
    assign wake_req  = wake_req_q;
    assign irq_gated = irq_in & {IRQ_W{gate_n_q}};

endmodule

// File: tb/tb_qchannel_ctrl.sv
// Scoreboard bench for qchannel_ctrl (QUIESCE_CYCLES=4, DENY_TIMEOUT=64,
// STAT_W=2). Covers both builds of QCH_DENY_EN.
module tb_qchannel_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        qreqn;
    logic        qacceptn;
    logic        qdeny;
    logic        bus_busy;
    logic        core_idle;
    logic [31:0] irq_in;
    logic [31:0] irq_mask;
    logic        gate_n;
    logic [31:0] irq_gated;
    logic        wake_req;
    logic [1:0]  stop_count;

    qchannel_ctrl #(
        .QUIESCE_CYCLES (4),
        .DENY_TIMEOUT   (64),
        .IRQ_W          (32),
        .STAT_W         (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .qreqn      (qreqn),
        .qacceptn   (qacceptn),
        .qdeny      (qdeny),
        .bus_busy   (bus_busy),
        .core_idle  (core_idle),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .gate_n     (gate_n),
        .irq_gated  (irq_gated),
        .wake_req   (wake_req),
        .stop_count (stop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        qa;
        logic        qd;
        logic        g;
        logic        w;
        logic [1:0]  sc;
        logic [31:0] ig;
    } obs_t;

    typedef struct {
        int unsigned cyc;
        obs_t        v;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [1:0]  sc = 2'd0;
    logic [7:0]  idle_pat = 8'b1111_0111;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        obs_t  got;
        exp_t  e;
        string nm;
        got = '{qacceptn, qdeny, gate_n, wake_req, stop_count, irq_gated};
        while ((exp_q.size() != 0) && (exp_q[0].cyc <= cyc)) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)", nm, e.cyc, cyc);
            end else if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s @%0d: got qacceptn=%b qdeny=%b gate_n=%b wake_req=%b stop_count=%0d irq_gated=%h, expected qacceptn=%b qdeny=%b gate_n=%b wake_req=%b stop_count=%0d irq_gated=%h",
                         nm, cyc, got.qa, got.qd, got.g, got.w, got.sc, got.ig,
                         e.v.qa, e.v.qd, e.v.g, e.v.w, e.v.sc, e.v.ig);
            end
        end
    end

    // Expect the given outputs dly edges from now; stop_count and irq_gated
    // come from the bench's own count and the irq_in currently driven.
    task automatic chk(input int unsigned dly, input logic qa, input logic qd,
                       input logic g, input logic w, input string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.v   = '{qa, qd, g, w, sc, (g ? irq_in : 32'h0)};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic qr, input logic bb, input logic ci);
        qreqn     = qr;
        bus_busy  = bb;
        core_idle = ci;
    endtask

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        irq_in   = 32'h0;
        irq_mask = 32'h0;
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 0, 0, 0, 0, "reset_a");
        chk(2, 0, 0, 0, 0, "reset_b");
        tick(2);

        resetn = 1'b1;
        chk(1, 1, 0, 1, 0, "run_after_reset");
        chk(3, 1, 0, 1, 0, "run_hold");
        tick(3);

        // Entry: gate drops after 1 edge, accept after 5.
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 1, 0, 0, 0, "entry_gate");
        chk(4, 1, 0, 0, 0, "entry_wait");
        sc = sat_inc(sc);
        chk(5, 0, 0, 0, 0, "entry_accept");
        tick(5);

        // Wake request from STOPPED, cleared on exit.
        irq_mask = 32'h1;
        irq_in   = 32'h1;
        chk(1, 0, 0, 0, 1, "wake_set");
        tick(1);
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "wake_clear");
        tick(1);
        irq_in = 32'h0;

        // Busy hold keeps RUN; DRAIN one edge after busy drops.
        drv(1'b0, 1'b1, 1'b1);
        chk(1, 1, 0, 1, 0, "busy_hold_a");
        chk(10, 1, 0, 1, 0, "busy_hold_b");
        tick(10);
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 1, 0, 0, 0, "busy_drain");
        sc = sat_inc(sc);
        chk(5, 0, 0, 0, 0, "busy_accept");
        tick(5);

        // Idle interruption: 1,1,1,0,1,1,1,1 accepts on the 8th cycle.
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "idle_run");
        tick(1);
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 1, 0, 0, 0, "idle_drain");
        tick(1);
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b0, idle_pat[i]);
            if (i == 7) begin
                sc = sat_inc(sc);
                chk(1, 0, 0, 0, 0, "idle_accept");
            end else begin
                chk(1, 1, 0, 0, 0, "idle_wait");
            end
            tick(1);
        end

        // Two more entries: stop_count saturates at 2'b11.
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, 1'b0, 1'b1);
            chk(1, 1, 0, 1, 0, "sat_run");
            tick(1);
            drv(1'b0, 1'b0, 1'b1);
            sc = sat_inc(sc);
            chk(5, 0, 0, 0, 0, "sat_accept");
            tick(5);
        end

        // qreqn rising during DRAIN is ignored.
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "viol_run");
        tick(1);
        drv(1'b0, 1'b0, 1'b0);
        chk(1, 1, 0, 0, 0, "viol_drain");
        tick(3);
        drv(1'b1, 1'b0, 1'b0);
        chk(3, 1, 0, 0, 0, "viol_ignored");
        tick(3);
        drv(1'b0, 1'b0, 1'b1);
        chk(3, 1, 0, 0, 0, "viol_wait");
        chk(4, 0, 0, 0, 0, "viol_accept");
        tick(4);

`ifdef QCH_DENY_EN
        // Deny on pending interrupt at request.
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "deny_run");
        tick(1);
        irq_in = 32'h1;
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 1, 1, 1, 0, "deny_set");
        chk(3, 1, 1, 1, 0, "deny_hold");
        tick(3);
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "deny_release");
        tick(1);
        irq_in = 32'h0;

        // Drain timeout after 64 DRAIN cycles.
        drv(1'b0, 1'b0, 1'b0);
        chk(1, 1, 0, 0, 0, "to_drain");
        chk(64, 1, 0, 0, 0, "to_wait");
        chk(65, 1, 1, 1, 0, "to_deny");
        tick(65);
        drv(1'b1, 1'b0, 1'b0);
        chk(1, 1, 0, 1, 0, "to_release");
        tick(1);

        // Interrupt arriving during DRAIN denies.
        drv(1'b0, 1'b0, 1'b0);
        chk(1, 1, 0, 0, 0, "pend_drain");
        tick(1);
        irq_in = 32'h1;
        chk(1, 1, 1, 1, 0, "pend_deny");
        tick(1);
        irq_in = 32'h0;
        drv(1'b1, 1'b0, 1'b0);
        chk(1, 1, 0, 1, 0, "pend_release");
        tick(1);

        // Accept wins over a coincident interrupt.
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 1, 0, 0, 0, "prio_drain");
        tick(4);
        irq_in = 32'h1;
        chk(1, 0, 0, 0, 0, "prio_accept");
        tick(1);
        chk(1, 0, 0, 0, 1, "prio_wake");
        tick(1);
        irq_in = 32'h0;
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "prio_run");
        tick(1);
`else
        // Without deny: pending interrupt does not block entry.
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "nodeny_run");
        tick(1);
        irq_in = 32'h1;
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 1, 0, 0, 0, "nodeny_drain");
        chk(5, 0, 0, 0, 0, "nodeny_accept");
        chk(6, 0, 0, 0, 1, "nodeny_wake");
        tick(6);
        irq_in = 32'h0;
        drv(1'b1, 1'b0, 1'b0);
        chk(1, 1, 0, 1, 0, "nodeny_run2");
        tick(1);

        // Without deny: DRAIN waits past the timeout value.
        drv(1'b0, 1'b0, 1'b0);
        chk(1, 1, 0, 0, 0, "noto_drain");
        chk(80, 1, 0, 0, 0, "noto_wait");
        tick(80);
        drv(1'b0, 1'b0, 1'b1);
        chk(3, 1, 0, 0, 0, "noto_idle");
        chk(4, 0, 0, 0, 0, "noto_accept");
        tick(4);
`endif

        // Reset from RUN returns to STOPPED regardless of qreqn.
        drv(1'b1, 1'b0, 1'b1);
        chk(1, 1, 0, 1, 0, "rst_run");
        tick(1);
        resetn = 1'b0;
        sc     = 2'd0;
        chk(1, 0, 0, 0, 0, "rst_stopped");
        tick(1);
        resetn = 1'b1;
        drv(1'b0, 1'b0, 1'b1);
        chk(1, 0, 0, 0, 0, "rst_hold_stopped");
        tick(1);

        for (int i = 0; (i < 5) && (exp_q.size() != 0); i++) tick(1);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
            n_fail += exp_q.size();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
